flexbex_ibex_efpga_ctrl: RTL and testbench

Execute-stage controller for custom eFPGA instructions (opcode 0x0B) issued by the ID-stage decoder. It consumes the decoder's eFPGA enable, operator and delay fields plus the two register operands. It launches the operation into the eFPGA fabric, times it with a fixed cycle count or a done handshake, and returns a 32-bit result for register write-back. While an operation is in flight it stalls the pipeline through ready_o.

---
 rtl/flexbex_ibex_efpga_pkg.sv | 32 +++
 rtl/flexbex_ibex_efpga_timer.sv | 54 +++++
 rtl/flexbex_ibex_efpga_ctrl.sv | 123 ++++++++++++
 tb/tb_flexbex_ibex_efpga_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flexbex_ibex_efpga_pkg.sv
// Shared definitions for the eFPGA execute-stage controller:
// FSM state encoding, operator (result select) encodings and the opcode.
package flexbex_ibex_efpga_pkg;

   typedef enum logic [1:0] {
      EFPGA_IDLE   = 2'd0,
      EFPGA_LAUNCH = 2'd1,
      EFPGA_WAIT   = 2'd2,
      EFPGA_DONE   = 2'd3
   } efpga_state_e;

   localparam logic [1:0] EFPGA_SEL_A    = 2'b00;
   localparam logic [1:0] EFPGA_SEL_B    = 2'b01;
   localparam logic [1:0] EFPGA_SEL_C    = 2'b10;
   localparam logic [1:0] EFPGA_SEL_NONE = 2'b11;

   localparam logic [6:0] OPCODE_EFPGA = 7'h0B;

   // Write-only operations return 0 so the write-back still has a defined value.
   function automatic logic [31:0] efpga_sel_result(input logic [1:0]  op,
                                                     input logic [31:0] res_a,
                                                     input logic [31:0] res_b,
                                                     input logic [31:0] res_c);
      case (op)
         EFPGA_SEL_A: return res_a;
         EFPGA_SEL_B: return res_b;
         EFPGA_SEL_C: return res_c;
         default:     return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/flexbex_ibex_efpga_timer.sv
// Latency timer for eFPGA operations: fixed-delay down-counter plus an
// optional handshake watchdog (present only with FLEXBEX_EFPGA_TIMEOUT_EN).
// expire pulses in the last fixed-mode WAIT cycle; timeout pulses once the
// watchdog has seen TIMEOUT_CYCLES handshake WAIT cycles without completion.
module flexbex_ibex_efpga_timer #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] delay,
   input  logic             run,
   input  logic             hs_mode,
   output logic             expire,
   output logic             timeout
);

   logic [CNT_W-1:0] cnt_q;

   // Delay counter: loaded in LAUNCH, counts down while waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= delay;
      end else if (run && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expire = run && !hs_mode && (cnt_q == CNT_W'(1));

`ifdef FLEXBEX_EFPGA_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q;

   // Watchdog: cleared on launch, saturates at the limit during handshake waits.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         wd_q <= '0;
      end else if (run && hs_mode && (wd_q != WD_W'(TIMEOUT_CYCLES))) begin
         wd_q <= wd_q + WD_W'(1);
      end
   end

   assign timeout = run && hs_mode && (wd_q == WD_W'(TIMEOUT_CYCLES));
`else
   // No watchdog: the comparison is constant false, so handshakes wait forever.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: rtl/flexbex_ibex_efpga_ctrl.sv
// Execute-stage controller for custom eFPGA instructions (opcode 0x0B).
// Launches an operation into the fabric, times it by fixed delay or by the
// fpga_done_i handshake, and returns a registered 32-bit result.
// Optional watchdog in handshake mode: FLEXBEX_EFPGA_TIMEOUT_EN.
//
// Handshake: an instruction is accepted in IDLE when en_i=1 and flush_i=0.
// ready_o=0 stalls ID/EX; it is ~en_i in IDLE, 0 in LAUNCH/WAIT and 1 in DONE.
// valid_o is a one-cycle pulse in DONE qualifying result_o and err_o; en_i
// seen in DONE belongs to the retiring instruction and is ignored.
import flexbex_ibex_efpga_pkg::*;

module flexbex_ibex_efpga_ctrl #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic [1:0]  operator_i,
   input  logic [3:0]  delay_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
   input  logic        flush_i,
   output logic [31:0] fpga_op_a_o,
   output logic [31:0] fpga_op_b_o,
   output logic [1:0]  fpga_op_o,
   output logic        fpga_strobe_o,
   input  logic [31:0] fpga_res_a_i,
   input  logic [31:0] fpga_res_b_i,
   input  logic [31:0] fpga_res_c_i,
   input  logic        fpga_done_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic        err_o,
   output logic [1:0]  dbg_state_o
);

   efpga_state_e     state_q, state_d;
   logic [CNT_W-1:0] delay_q;
   logic             accept, capture, done_hit, hs_mode;
   logic             cnt_expire, wd_expire;

   assign hs_mode  = (delay_q == '0);
   assign accept   = (state_q == EFPGA_IDLE) && en_i && !flush_i;
   assign done_hit = hs_mode && fpga_done_i;
   assign capture  = (state_q == EFPGA_WAIT) && !flush_i &&
                     (cnt_expire || done_hit || wd_expire);

   assign dbg_state_o = state_q;

   flexbex_ibex_efpga_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (state_q == EFPGA_LAUNCH),
      .delay  (delay_q),
      .run    (state_q == EFPGA_WAIT),
      .hs_mode(hs_mode),
      .expire (cnt_expire),
      .timeout(wd_expire)
   );

   // Next-state and stall logic; flush always wins and returns to IDLE.
   always_comb begin
      state_d = state_q;
      ready_o = 1'b0;
      case (state_q)
         EFPGA_IDLE: begin
            ready_o = ~en_i;
            if (accept) state_d = EFPGA_LAUNCH;
         end
         EFPGA_LAUNCH: state_d = flush_i ? EFPGA_IDLE : EFPGA_WAIT;
         EFPGA_WAIT: begin
            if (flush_i)      state_d = EFPGA_IDLE;
            else if (capture) state_d = EFPGA_DONE;
         end
         EFPGA_DONE: begin
            ready_o = 1'b1;
            state_d = EFPGA_IDLE;
         end
         default: state_d = EFPGA_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= EFPGA_IDLE;
      else     state_q <= state_d;
   end

   // Fabric-facing operand registers, launch strobe and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         fpga_op_a_o   <= '0;
         fpga_op_b_o   <= '0;
         fpga_op_o     <= '0;
         delay_q       <= '0;
         fpga_strobe_o <= 1'b0;
         valid_o       <= 1'b0;
         result_o      <= '0;
         err_o         <= 1'b0;
      end else begin
         fpga_strobe_o <= accept;
         valid_o       <= capture;
         err_o         <= capture && wd_expire && !done_hit;
         if (accept) begin
            fpga_op_a_o <= operand_a_i;
            fpga_op_b_o <= operand_b_i;
            fpga_op_o   <= operator_i;
            delay_q     <= CNT_W'(delay_i);
         end
         if (capture) begin
            if (wd_expire && !done_hit) result_o <= '0;
            else result_o <= efpga_sel_result(fpga_op_o, fpga_res_a_i,
                                              fpga_res_b_i, fpga_res_c_i);
         end
      end
   end

endmodule

// File: tb/tb_flexbex_ibex_efpga_ctrl.sv
// Bench for flexbex_ibex_efpga_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model
// that tracks each instruction by its accept cycle and completion cycle.
import flexbex_ibex_efpga_pkg::*;

module tb_flexbex_ibex_efpga_ctrl;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst, en, flush, done;
   logic [1:0]  op;
   logic [3:0]  delay;
   logic [31:0] a, b, res_a, res_b, res_c;
   logic [31:0] fpga_op_a, fpga_op_b, result;
   logic [1:0]  fpga_op, dbg_state;
   logic        strobe, ready, valid, err;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   // Model state (transaction level).
   int          cyc = 0;
   bit          busy = 0;
   int          acc = 0;
   int          fin = -1;
   logic [3:0]  m_dly = '0;
   bit          pend_err = 0;
   logic [31:0] m_a = '0, m_b = '0, m_result = '0;
   logic [1:0]  m_op = '0;
   logic        m_strobe = 0, m_valid = 0, m_err = 0;

   flexbex_ibex_efpga_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en),
      .operator_i   (op),
      .delay_i      (delay),
      .operand_a_i  (a),
      .operand_b_i  (b),
      .flush_i      (flush),
      .fpga_op_a_o  (fpga_op_a),
      .fpga_op_b_o  (fpga_op_b),
      .fpga_op_o    (fpga_op),
      .fpga_strobe_o(strobe),
      .fpga_res_a_i (res_a),
      .fpga_res_b_i (res_b),
      .fpga_res_c_i (res_c),
      .fpga_done_i  (done),
      .ready_o      (ready),
      .valid_o      (valid),
      .result_o     (result),
      .err_o        (err),
      .dbg_state_o  (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] pick(input logic [1:0] o);
      case (o)
         2'd0:    return res_a;
         2'd1:    return res_b;
         2'd2:    return res_c;
         default: return 32'd0;
      endcase
   endfunction

   // Model: advance one cycle using the inputs of the cycle just ending.
   always @(posedge clk) begin
      int c;
      c = cyc;
      m_strobe = 0;
      m_valid  = 0;
      m_err    = 0;
      if (rst) begin
         busy = 0; m_a = '0; m_b = '0; m_op = '0; m_result = '0;
      end else if (flush) begin
         busy = 0;
      end else if (!busy) begin
         if (en) begin
            busy = 1; acc = c; m_op = op; m_a = a; m_b = b; m_dly = delay;
            pend_err = 0; m_strobe = 1;
            fin = (delay != 0) ? c + 2 + int'(delay) : -1;
         end
      end else if (c == fin) begin
         busy = 0;
      end else if (c >= acc + 2) begin
         if (m_dly != 0) begin
            if (c == fin - 1) m_result = pick(m_op);
         end else if (fin < 0) begin
            if (done) begin
               fin = c + 1; m_result = pick(m_op);
            end
`ifdef FLEXBEX_EFPGA_TIMEOUT_EN
            else if (c == acc + 2 + TO) begin
               fin = c + 1; m_result = '0; pend_err = 1;
            end
`endif
         end
      end
      if (busy && (c + 1 == fin)) begin
         m_valid = 1;
         m_err   = pend_err;
      end
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_check();
      logic [1:0] st;
      logic       rdy;
      if (!busy)              begin st = EFPGA_IDLE;   rdy = ~en; end
      else if (cyc == acc+1)  begin st = EFPGA_LAUNCH; rdy = 1'b0; end
      else if (cyc == fin)    begin st = EFPGA_DONE;   rdy = 1'b1; end
      else                    begin st = EFPGA_WAIT;   rdy = 1'b0; end
      chk("state",  32'(dbg_state), 32'(st));
      chk("ready",  32'(ready),     32'(rdy));
      chk("strobe", 32'(strobe),    32'(m_strobe));
      chk("valid",  32'(valid),     32'(m_valid));
      chk("err",    32'(err),       32'(m_err));
      chk("result", result,         m_result);
      chk("op_a",   fpga_op_a,      m_a);
      chk("op_b",   fpga_op_b,      m_b);
      chk("op",     32'(fpga_op),   32'(m_op));
   endtask

   // Inputs for the current cycle are set before calling; check, then advance.
   task automatic cycle();
      #1;
      if (chk_en) model_check();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic quiet();
      en = 0; flush = 0; done = 0; rst = 0;
   endtask

   initial begin
      quiet();
      rst = 1; op = '0; delay = '0; a = '0; b = '0;
      res_a = '0; res_b = '0; res_c = '0;
      repeat (2) @(negedge clk);
      chk_en = 1;
      chk("rst_state",  32'(dbg_state), 32'(EFPGA_IDLE));
      chk("rst_result", result, 32'd0);
      chk("rst_valid",  32'(valid), 32'd0);
      rst = 0;
      run(2);

      // Fixed latency, delay 3, select B.
      en = 1; delay = 4'd3; op = 2'b01; a = 32'h1111_0001; b = 32'h2222_0002;
      res_b = 32'hDEAD_BEEF;
      cycle();
      chk("fix_strobe_T1", 32'(strobe), 32'd1);
      en = 0;
      run(4);
      chk("fix_valid_T5",  32'(valid), 32'd1);
      chk("fix_result_T5", result, 32'hDEAD_BEEF);
      run(2);

      // Handshake, select C, done at T+6.
      en = 1; delay = 4'd0; op = 2'b10; res_c = 32'h1234_5678;
      cycle();
      en = 0;
      run(5);
      done = 1;
      cycle();
      done = 0;
      chk("hs_valid_T7",  32'(valid), 32'd1);
      chk("hs_result_T7", result, 32'h1234_5678);
      run(2);

      // Write-only with en held, then back-to-back select A.
      en = 1; delay = 4'd1; op = 2'b11; res_a = 32'hA5A5_A5A5;
      cycle();
      chk("wo_strobe_T1", 32'(strobe), 32'd1);
      run(2);
      chk("wo_valid_T3",  32'(valid), 32'd1);
      chk("wo_result_T3", result, 32'd0);
      op = 2'b00; delay = 4'd2;
      cycle();
      chk("b2b_idle_T4",   32'(dbg_state), 32'(EFPGA_IDLE));
      chk("b2b_nostrb_T4", 32'(strobe), 32'd0);
      cycle();
      chk("b2b_strobe_T5", 32'(strobe), 32'd1);
      en = 0;
      run(3);
      chk("b2b_valid",  32'(valid), 32'd1);
      chk("b2b_result", result, 32'hA5A5_A5A5);
      run(2);

      // Flush during WAIT.
      en = 1; delay = 4'd8; op = 2'b01;
      cycle();
      en = 0;
      run(3);
      flush = 1;
      cycle();
      flush = 0;
      chk("fl_state_T5", 32'(dbg_state), 32'(EFPGA_IDLE));
      chk("fl_valid_T5", 32'(valid), 32'd0);
      run(12);

      // Handshake with no completion.
      en = 1; delay = 4'd0; op = 2'b00;
      cycle();
      en = 0;
`ifdef FLEXBEX_EFPGA_TIMEOUT_EN
      run(18);
      chk("to_valid_T19",  32'(valid), 32'd1);
      chk("to_err_T19",    32'(err), 32'd1);
      chk("to_result_T19", result, 32'd0);
`else
      run(30);
      chk("nowd_still_wait", 32'(dbg_state), 32'(EFPGA_WAIT));
      flush = 1;
      cycle();
      flush = 0;
`endif
      run(2);

      // Reset mid-WAIT.
      en = 1; delay = 4'd5; op = 2'b01; a = 32'hCAFE_0001; b = 32'hCAFE_0002;
      cycle();
      en = 0;
      run(2);
      rst = 1;
      cycle();
      rst = 0;
      chk("rm_state", 32'(dbg_state), 32'(EFPGA_IDLE));
      chk("rm_op_a",  fpga_op_a, 32'd0);
      chk("rm_op_b",  fpga_op_b, 32'd0);
      chk("rm_op",    32'(fpga_op), 32'd0);
      chk("rm_strb",  32'(strobe), 32'd0);
      chk("rm_valid", 32'(valid), 32'd0);
      chk("rm_res",   result, 32'd0);
      chk("rm_err",   32'(err), 32'd0);
      run(2);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         en    = ($urandom_range(0, 3) == 0);
         op    = 2'($urandom_range(0, 3));
         delay = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         a     = $urandom; b = $urandom;
         res_a = $urandom; res_b = $urandom; res_c = $urandom;
         done  = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 49) == 0);
         rst   = ($urandom_range(0, 299) == 0);
         cycle();
      end
      quiet();
      run(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
